// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel-to-serial feeder with one-entry holding register
// Words are staged in a holding register and shifted out one bit per bit_en strobe, gapless back-to-back.
module bit_stream_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             accept;
  logic             xfer;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // in_ready depends only on registered state, so accept and transfer are mutually exclusive.
  assign accept = in_valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    xfer        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          xfer    = 1'b1;
          shreg_d = hold_q;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_en) begin
          if (cnt_q == LAST_CNT) begin
            if (hold_full_q) begin
              xfer    = 1'b1;
              shreg_d = hold_q;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            shreg_d = advance(shreg_q);
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      hold_full_d = 1'b1;
    end else if (xfer) begin
      hold_full_d = 1'b0;
    end

    // Outputs are computed from next state so sout and flags come straight from flops.
    sout_valid_d = (state_d == S_SHIFT);
    sout_d       = sout_valid_d ? head_bit(shreg_d) : IDLE_BIT;
    last_bit_d   = sout_valid_d && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      last_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_bit_q   <= last_bit_d;
      if (accept) begin
        hold_q <= in_data;
      end
    end
  end

  assign in_ready   = !hold_full_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = (state_q == S_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb/tb_bit_stream_serializer.sv - scoreboard bench for bit_stream_serializer
// MSB-first and LSB-first instances; expected bit sequences are queued by stimulus, popped by monitors.
module tb_bit_stream_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] m_in_data = '0;
  logic       m_in_valid = 1'b0;
  logic       m_in_ready;
  logic       m_bit_en = 1'b1;
  logic       m_sout, m_sout_valid, m_last_bit, m_busy;

  logic [7:0] l_in_data = '0;
  logic       l_in_valid = 1'b0;
  logic       l_in_ready;
  logic       l_bit_en = 1'b1;
  logic       l_sout, l_sout_valid, l_last_bit, l_busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_q[$];
  logic [1:0] l_q[$];

  logic       det_en = 1'b0;
  logic [3:0] det_sr = '0;
  int         det_count = 0;

  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst),
    .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .bit_en(m_bit_en), .sout(m_sout), .sout_valid(m_sout_valid),
    .last_bit(m_last_bit), .busy(m_busy)
  );

  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .bit_en(l_bit_en), .sout(l_sout), .sout_valid(l_sout_valid),
    .last_bit(l_last_bit), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // seq lists bits in emission order, leftmost first.
  task automatic push_seq(input bit to_lsb, input logic [7:0] seq, input int reps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      logic lst;
      b   = seq[7-i];
      lst = (nbits == 8) && (i == 7);
      for (int r = 0; r < reps; r++) begin
        if (to_lsb) l_q.push_back({b, lst});
        else        m_q.push_back({b, lst});
      end
    end
  endtask

  initial begin : mon_msb
    logic [1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_sout_valid) begin
          if (det_en) begin
            det_sr = {det_sr[2:0], m_sout};
            if (det_sr == 4'b1011) det_count++;
          end
          if (m_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL msb_unexpected_bit: got sout=%0b with no bit expected at %0t", m_sout, $time);
          end else begin
            exp = m_q.pop_front();
            check("msb_bit", {6'b0, m_sout, m_last_bit}, {6'b0, exp});
          end
        end else begin
          check("msb_idle", {6'b0, m_sout, m_last_bit}, 8'h00);
        end
      end
    end
  end

  initial begin : mon_lsb
    logic [1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (l_sout_valid) begin
          if (l_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lsb_unexpected_bit: got sout=%0b with no bit expected at %0t", l_sout, $time);
          end else begin
            exp = l_q.pop_front();
            check("lsb_bit", {6'b0, l_sout, l_last_bit}, {6'b0, exp});
          end
        end else begin
          check("lsb_idle", {6'b0, l_sout, l_last_bit}, 8'h00);
        end
      end
    end
  end

  task automatic send_m(input logic [7:0] d);
    int t;
    t = 0;
    m_in_data  = d;
    m_in_valid = 1'b1;
    while (!m_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("msb_accept_timeout", 8'(t < 50), 8'h01);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
  endtask

  task automatic send_l(input logic [7:0] d);
    int t;
    t = 0;
    l_in_data  = d;
    l_in_valid = 1'b1;
    while (!l_in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("lsb_accept_timeout", 8'(t < 50), 8'h01);
    @(posedge clk); #1;
    l_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit is_lsb);
    int t;
    t = 0;
    while ((is_lsb ? l_q.size() : m_q.size()) != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check(is_lsb ? "lsb_drain_timeout" : "msb_drain_timeout", 8'(t < 300), 8'h01);
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_idle_sout", {7'b0, m_sout}, 8'h00);
      check("rst_idle_valid", {7'b0, m_sout_valid}, 8'h00);
      check("rst_idle_ready", {7'b0, m_in_ready}, 8'h01);
      check("rst_idle_busy", {7'b0, m_busy}, 8'h00);
    end

    // Single word B0, MSB first, fed into a 1011 detector model
    det_sr    = '0;
    det_count = 0;
    det_en    = 1'b1;
    push_seq(1'b0, 8'b10110000, 1, 8);
    send_m(8'hB0);
    check("lat_valid_after_accept", {7'b0, m_sout_valid}, 8'h00);
    check("lat_busy_after_accept", {7'b0, m_busy}, 8'h01);
    check("lat_ready_after_accept", {7'b0, m_in_ready}, 8'h00);
    @(posedge clk); #1;
    check("lat_first_bit_valid", {7'b0, m_sout_valid}, 8'h01);
    wait_drain(1'b0);
    @(posedge clk); #1;
    check("single_done_valid", {7'b0, m_sout_valid}, 8'h00);
    check("single_done_busy", {7'b0, m_busy}, 8'h00);
    det_en = 1'b0;
    check("detector_hits", 8'(det_count), 8'h01);

    // Back-to-back A5 then 3C, in_valid held high
    push_seq(1'b0, 8'b10100101, 1, 8);
    push_seq(1'b0, 8'b00111100, 1, 8);
    m_in_data  = 8'hA5;
    m_in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_ready_k", {7'b0, m_in_ready}, 8'h00);
    m_in_data = 8'h3C;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check("b2b_contiguous", {7'b0, m_sout_valid}, 8'h01);
      if (i == 1) check("b2b_ready_k1", {7'b0, m_in_ready}, 8'h01);
      if (i == 2) begin
        check("b2b_ready_k2", {7'b0, m_in_ready}, 8'h00);
        m_in_valid = 1'b0;
      end
      if (i == 8) check("b2b_ready_k8", {7'b0, m_in_ready}, 8'h00);
      if (i == 9) check("b2b_ready_k9", {7'b0, m_in_ready}, 8'h01);
    end
    @(posedge clk); #1;
    check("b2b_done_valid", {7'b0, m_sout_valid}, 8'h00);

    // Throttled: bit_en high one cycle in three, each bit held three cycles
    push_seq(1'b0, 8'b11110000, 3, 8);
    m_bit_en = 1'b0;
    send_m(8'hF0);
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      m_bit_en = (i % 3 == 2);
      @(posedge clk); #1;
    end
    m_bit_en = 1'b1;
    check("thr_done_valid", {7'b0, m_sout_valid}, 8'h00);
    check("thr_queue_empty", 8'(m_q.size()), 8'h00);

    // LSB-first instance
    push_seq(1'b1, 8'b10000000, 1, 8);
    push_seq(1'b1, 8'b00001101, 1, 8);
    send_l(8'h01);
    send_l(8'hB0);
    wait_drain(1'b1);

    // Reset mid-word with a second word held
    push_seq(1'b0, 8'b11100000, 1, 3);
    m_in_data  = 8'hFF;
    m_in_valid = 1'b1;
    @(posedge clk); #1;
    m_in_data = 8'h81;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {7'b0, m_busy}, 8'h01);
    check("mid_ready", {7'b0, m_in_ready}, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sout", {7'b0, m_sout}, 8'h00);
    check("async_rst_valid", {7'b0, m_sout_valid}, 8'h00);
    check("async_rst_last", {7'b0, m_last_bit}, 8'h00);
    check("async_rst_ready", {7'b0, m_in_ready}, 8'h01);
    check("async_rst_busy", {7'b0, m_busy}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_msb_queue", 8'(m_q.size()), 8'h00);
    check("post_rst_lsb_queue", 8'(l_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
